run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_KHZ, default 50000, clock frequency in kHz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20; DEB_CYC = CLK_FREQ_KHZ*DEBOUNCE_MS.
REQ-003 SHALL have parameter LONG_PRESS_MS, default 1000; LONG_CYC = CLK_FREQ_KHZ*LONG_PRESS_MS.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port key_n, input, 2, raw asynchronous push-buttons, active-low; bit0 start/pause, bit1 clear.
REQ-007 SHALL have port tick_1s, input, 1, one-cycle 1 s strobe from the second counter.
REQ-008 SHALL have port timeup, input, 1, level from the digit chain indicating the limit was reached.
REQ-009 SHALL have port count_en, output, 1, tick_1s gated by RUN; drives the digit chain's countup strobe.
REQ-010 SHALL have port clr, output, 1, one-cycle pulse that zeroes the digit chain.
REQ-011 SHALL have port state, output, 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-012 SHALL have port key_press, output, 2, one-cycle debounced press events (for LEDs/diagnostics).

Function
REQ-013 Each key_n bit SHALL pass a 2-flop synchronizer; pressed level p[i] = ~synchronized key_n[i].
REQ-014 Debounced level db[i] SHALL update to p[i] only after p[i] differs from db[i] for DEB_CYC consecutive cycles; any cycle with p[i]==db[i] SHALL zero that key's counter.
REQ-015 key_press[i] SHALL be 1 exactly in the first cycle db[i] is 1 after being 0 (combinational from db and its one-cycle delay).
REQ-016 Hold counter SHALL count cycles with db[1]=1, saturating at LONG_CYC; long event SHALL fire once, in the cycle the count reaches LONG_CYC-1.
REQ-017 Short-clear event SHALL fire in the cycle db[1] falls, only if long event did not fire during that press.
REQ-018 Clear request = long event (any state) OR short-clear event (state != RUN); short-clear in RUN SHALL be ignored.
REQ-019 FSM transitions on the edge after the event: IDLE+key_press[0] -> RUN; RUN+key_press[0] -> PAUSE; PAUSE+key_press[0] -> RUN; RUN+timeup -> DONE; any state+clear request -> IDLE.
REQ-020 DONE SHALL ignore key_press[0]; only a clear request leaves DONE.
REQ-021 Priority within one cycle: clear request > timeup > key_press[0].
REQ-022 timeup observed in IDLE or PAUSE SHALL NOT change state; IDLE+key_press[0] while timeup=1 SHALL go to RUN then DONE next cycle.
REQ-023 clr SHALL be registered: high for exactly one cycle, coincident with the first cycle state==IDLE after a clear request (also when already IDLE).
REQ-024 count_en SHALL equal tick_1s AND (state==RUN), combinational, zero added latency.
REQ-025 Counter widths SHALL be $clog2 of their limit+1; no wrap of debounce or hold counters.

Reset
REQ-026 With rst=1 at a clock edge: state=IDLE, clr=0, db=0, synchronizer flops=0 (released), all counters=0, long-fired flag=0.
REQ-027 count_en and key_press SHALL be 0 during and one cycle after reset.
REQ-028 Reset mid-press SHALL discard the press; a key held through reset SHALL yield key_press only after DEB_CYC cycles post-reset, once.

Verification (CLK_FREQ_KHZ=1, DEBOUNCE_MS=4, LONG_PRESS_MS=20 -> DEB_CYC=4, LONG_CYC=20)
REQ-029 key_n[0] low at cycle 0, held 10 cycles -> key_press[0] pulse at cycle 6, state=RUN at cycle 7; tick_1s then -> count_en=1 same cycle.
REQ-030 key_n[0] glitches low 3 cycles, high 2, repeated -> no key_press, state stays IDLE.
REQ-031 RUN, timeup=1 and key_press[0] same cycle -> state=DONE; further key_n[0] presses -> state stays DONE, count_en=0.
REQ-032 DONE, key_n[1] pressed 8 cycles then released -> clr one-cycle pulse, state=IDLE; same in RUN -> ignored, state RUN.
REQ-033 RUN, key_n[1] held 40 cycles -> exactly one clr pulse, 20 cycles after db[1] rises; no second clr on release.
REQ-034 rst asserted while PAUSE and key_n[0] held -> state=IDLE, clr=0; after release of rst, one key_press[0] at 6th post-reset cycle.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: front-panel control for a count-up timer.
// Debounces the start/pause and clear keys, separates short and long presses of
// clear, and runs the IDLE/RUN/PAUSE/DONE state machine that gates the seconds
// strobe into the digit chain.
module run_ctrl #(
  parameter int CLK_FREQ_KHZ  = 50000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic       tick_1s,
  input  logic       timeup,
  output logic       count_en,
  output logic       clr,
  output logic [1:0] state,
  output logic [1:0] key_press
);

  localparam int DEB_CYC  = CLK_FREQ_KHZ * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ_KHZ * LONG_PRESS_MS;
  localparam int DEB_W    = $clog2(DEB_CYC + 1);
  localparam int LONG_W   = $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // The synchronizer stores the pressed level (inverted key_n) so that its
  // cleared value means "released".
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       pressed;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [LONG_W-1:0] hold_cnt;
  logic              long_fired;
  logic              long_evt;
  logic              short_evt;
  logic              clear_req;

  assign pressed   = sync_b;
  assign key_press = db & ~db_d;

  // Synchronize both keys and debounce each one with its own stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_d   <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_a <= ~key_n;
      sync_b <= sync_a;
      db_d   <= db;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          db[i]      <= pressed[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Long press fires once when the hold count passes through its last value;
  // the saturating counter guarantees it cannot fire again in the same press.
  assign long_evt  = db[1] && (hold_cnt == LONG_LAST);
  assign short_evt = db_d[1] && !db[1] && !long_fired;
  assign clear_req = long_evt || (short_evt && (state_q != RUN));

  // Measure how long the clear key has been held and remember a long press
  // until the key is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
    end else if (!db[1]) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
    end else begin
      if (hold_cnt != LONG_MAX) begin
        hold_cnt <= hold_cnt + LONG_W'(1);
      end
      if (long_evt) begin
        long_fired <= 1'b1;
      end
    end
  end

  // Next-state logic: clear beats timeup, timeup beats start/pause.
  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (key_press[0]) state_d = RUN;
        RUN: begin
          if (timeup) begin
            state_d = DONE;
          end else if (key_press[0]) begin
            state_d = PAUSE;
          end
        end
        PAUSE:   if (key_press[0]) state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; clr is registered so it lines up with the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr     <= 1'b0;
    end else begin
      state_q <= state_d;
      clr     <= clear_req;
    end
  end

  assign count_en = tick_1s && (state_q == RUN);
  assign state    = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed test of run_ctrl with short debounce and long-press
// times (DEB_CYC=4, LONG_CYC=20). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
module tb_run_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic       tick_1s;
  logic       timeup;
  logic       count_en;
  logic       clr;
  logic [1:0] state;
  logic [1:0] key_press;

  int total = 0;
  int bad   = 0;

  int cyc        = 0;
  int kp0_count  = 0;
  int kp1_count  = 0;
  int clr_count  = 0;
  int kp1_cycle  = 0;
  int clr_cycle  = 0;
  logic [1:0] clr_state = 2'd0;

  run_ctrl #(
    .CLK_FREQ_KHZ (1),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .tick_1s  (tick_1s),
    .timeup   (timeup),
    .count_en (count_en),
    .clr      (clr),
    .state    (state),
    .key_press(key_press)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one cycle and record output events seen in the new cycle.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    if (key_press[0]) kp0_count++;
    if (key_press[1]) begin
      kp1_count++;
      kp1_cycle = cyc;
    end
    if (clr) begin
      clr_count++;
      clr_cycle = cyc;
      clr_state = state;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] keys, input int cycles);
    key_n = keys;
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_n   = 2'b11;
    tick_1s = 1'b1;
    timeup  = 1'b0;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_clr", clr, 0);
    checkOutput("rst_kp", key_press, 0);
    checkOutput("rst_cnten", count_en, 0);
    rst = 1'b0;
    checkOutput("post_rst_kp", key_press, 0);
    checkOutput("post_rst_cnten", count_en, 0);
    tick_1s = 1'b0;
    stepCycle();

    // Glitchy start key: never stable for 4 cycles.
    kp0_count = 0;
    repeat (4) begin
      applyStimulus(2'b10, 3);
      applyStimulus(2'b11, 2);
    end
    applyStimulus(2'b11, 8);
    checkOutput("glitch_kp", kp0_count, 0);
    checkOutput("glitch_state", state, 0);

    // Clean start press: event in cycle 6, RUN in cycle 7.
    applyStimulus(2'b10, 5);
    checkOutput("kp_c5", key_press[0], 0);
    stepCycle();
    checkOutput("kp_c6", key_press[0], 1);
    checkOutput("state_c6", state, 0);
    stepCycle();
    checkOutput("state_c7", state, 1);
    applyStimulus(2'b10, 2);
    tick_1s = 1'b1;
    #1;
    checkOutput("cnten_run", count_en, 1);
    tick_1s = 1'b0;
    applyStimulus(2'b11, 12);
    checkOutput("run_hold", state, 1);

    // Pause; timeup and ticks are ignored while paused.
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("pause_state", state, 2);
    tick_1s = 1'b1;
    timeup  = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("pause_cnten", count_en, 0);
    checkOutput("pause_timeup", state, 2);
    tick_1s = 1'b0;
    timeup  = 1'b0;
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("resume", state, 1);

    // timeup and start/pause in the same cycle: timeup wins.
    applyStimulus(2'b10, 6);
    checkOutput("same_kp", key_press[0], 1);
    timeup = 1'b1;
    stepCycle();
    checkOutput("timeup_wins", state, 3);
    timeup = 1'b0;
    applyStimulus(2'b10, 4);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("done_ignore", state, 3);
    tick_1s = 1'b1;
    #1;
    checkOutput("done_cnten", count_en, 0);
    tick_1s = 1'b0;

    // Short clear leaves DONE.
    clr_count = 0;
    applyStimulus(2'b01, 8);
    applyStimulus(2'b11, 12);
    checkOutput("short_clr_cnt", clr_count, 1);
    checkOutput("short_clr_state", clr_state, 0);
    checkOutput("done_cleared", state, 0);

    // Short clear while already IDLE still pulses clr.
    clr_count = 0;
    applyStimulus(2'b01, 8);
    applyStimulus(2'b11, 12);
    checkOutput("idle_clr_cnt", clr_count, 1);
    checkOutput("idle_clr_state", state, 0);

    // Short clear in RUN is ignored.
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("run_again", state, 1);
    clr_count = 0;
    applyStimulus(2'b01, 8);
    applyStimulus(2'b11, 12);
    checkOutput("run_short_ignored", clr_count, 0);
    checkOutput("run_short_state", state, 1);

    // Long clear in RUN: one clr, 20 cycles after the debounced press.
    clr_count = 0;
    kp1_count = 0;
    applyStimulus(2'b01, 40);
    checkOutput("long_clr_held", clr_count, 1);
    applyStimulus(2'b11, 12);
    checkOutput("long_clr_cnt", clr_count, 1);
    checkOutput("long_kp1", kp1_count, 1);
    checkOutput("long_delay", clr_cycle - kp1_cycle, 20);
    checkOutput("long_clr_state", clr_state, 0);
    checkOutput("long_state", state, 0);

    // Start pressed in IDLE while timeup is high: RUN, then DONE.
    timeup = 1'b1;
    applyStimulus(2'b10, 6);
    checkOutput("idle_timeup_state", state, 0);
    checkOutput("idle_timeup_kp", key_press[0], 1);
    stepCycle();
    checkOutput("idle_kp_run", state, 1);
    stepCycle();
    checkOutput("run_then_done", state, 3);
    timeup = 1'b0;
    applyStimulus(2'b11, 12);
    applyStimulus(2'b01, 8);
    applyStimulus(2'b11, 12);
    checkOutput("done_to_idle", state, 0);

    // Reset during PAUSE with the start key held.
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 10);
    checkOutput("pause2", state, 2);
    applyStimulus(2'b10, 3);
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rst_pause_state", state, 0);
    checkOutput("rst_pause_clr", clr, 0);
    rst = 1'b0;
    kp0_count = 0;
    checkOutput("rst_release_kp", key_press, 0);
    applyStimulus(2'b10, 5);
    checkOutput("rst_kp_c5", kp0_count, 0);
    stepCycle();
    checkOutput("rst_kp_c6", key_press[0], 1);
    applyStimulus(2'b10, 4);
    applyStimulus(2'b11, 10);
    checkOutput("rst_kp_once", kp0_count, 1);
    checkOutput("rst_kp_run", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
